xge_pkt_rx_reader: RTL and testbench

Receive-side drain engine for the 10GbE MAC packet receive interface. It issues `pkt_rx_ren` whenever the MAC reports a frame available, captures the returned words, and checks framing and length. Frames are forwarded on a valid/ready stream with a per-frame byte count. It sits between the MAC `pkt_rx_*` port and downstream packet consumers, in the `clk_156m25` domain.

---
 rtl/xge_mac_pkg.sv | 20 ++
 rtl/xge_rx_fifo.sv | 46 ++++
 rtl/xge_pkt_rx_reader.sv | 168 ++++++++++++++++
 tb/tb_xge_pkt_rx_reader.sv | 272 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/xge_mac_pkg.sv
// Shared types and helpers for the 10GbE MAC packet receive path.
package xge_mac_pkg;

  localparam int unsigned XGE_WORD_BYTES = 8;
  localparam int unsigned XGE_LEN_W      = 16;

  typedef struct packed {
    logic [63:0] data;
    logic        sop;
    logic        eop;
    logic [2:0]  mod;
    logic        err;
  } xge_word_t;

  // Valid byte count of an eop word; mod of 0 means a full word.
  function automatic logic [3:0] mod_to_bytes(input logic [2:0] mod);
    return (mod == 3'd0) ? 4'(XGE_WORD_BYTES) : {1'b0, mod};
  endfunction

endpackage

// File: rtl/xge_rx_fifo.sv
// First-word fall-through FIFO of xge_word_t with an occupancy count.
module xge_rx_fifo
  import xge_mac_pkg::*;
#(
  parameter int unsigned FIFO_DEPTH = 4,
  localparam int unsigned AW = $clog2(FIFO_DEPTH)
) (
  input  logic      clk_i,
  input  logic      rst_ni,
  input  logic      push_i,
  input  xge_word_t wdata_i,
  input  logic      pop_i,
  output xge_word_t rdata_o,
  output logic      empty_o,
  output logic [AW:0] count_o
);

  xge_word_t     mem_q [FIFO_DEPTH];
  logic [AW-1:0] wr_ptr_q, rd_ptr_q;
  logic [AW:0]   count_q;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      for (int unsigned i = 0; i < FIFO_DEPTH; i++) mem_q[i] <= '0;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (push_i) begin
        mem_q[wr_ptr_q] <= wdata_i;
        wr_ptr_q        <= wr_ptr_q + 1'b1;
      end
      if (pop_i) rd_ptr_q <= rd_ptr_q + 1'b1;
      case ({push_i, pop_i})
        2'b10:   count_q <= count_q + 1'b1;
        2'b01:   count_q <= count_q - 1'b1;
        default: count_q <= count_q;
      endcase
    end
  end

  assign rdata_o = mem_q[rd_ptr_q];
  assign empty_o = (count_q == '0);
  assign count_o = count_q;

endmodule

// File: rtl/xge_pkt_rx_reader.sv
// Drains frames from the MAC pkt_rx port into a valid/ready stream with length checks.
// Define XGE_RX_STATS_EN to build the frame ok/error counters; otherwise they read 0.
module xge_pkt_rx_reader
  import xge_mac_pkg::*;
#(
  parameter int unsigned FIFO_DEPTH      = 4,
  parameter int unsigned MAX_FRAME_BYTES = 1518
) (
  input  logic        clk_156m25,
  input  logic        reset_156m25_n,
  input  logic        pkt_rx_avail,
  input  logic        pkt_rx_val,
  input  logic [63:0] pkt_rx_data,
  input  logic        pkt_rx_sop,
  input  logic        pkt_rx_eop,
  input  logic [2:0]  pkt_rx_mod,
  input  logic        pkt_rx_err,
  output logic        pkt_rx_ren,
  output logic [63:0] out_data,
  output logic        out_sop,
  output logic        out_eop,
  output logic        out_err,
  output logic [2:0]  out_mod,
  output logic        out_val,
  input  logic        out_rdy,
  output logic [15:0] rx_len,
  output logic        rx_len_vld,
  output logic [31:0] stat_frames_ok,
  output logic [31:0] stat_frames_err
);

  localparam int unsigned AW = $clog2(FIFO_DEPTH);
  localparam int unsigned CW = AW + 2;
  localparam logic [CW-1:0] DepthL = CW'(FIFO_DEPTH);
  localparam logic [12:0] WcntMax = 13'd8191;

  localparam logic [0:0] StIdle = 1'b0;
  localparam logic [0:0] StRead = 1'b1;

  logic [0:0]  state_q, state_d;
  logic        inflight_q;
  logic        in_frame_q, in_frame_d;
  logic [12:0] wcnt_q, wcnt_d;
  logic [15:0] rx_len_q, rx_len_d;
  logic        rx_len_vld_q;

  logic        sop_new, cont, orphan, collision;
  logic [12:0] words;
  logic [3:0]  mod_bytes;
  logic [19:0] len_raw;
  logic [15:0] frame_len;
  logic        eop_word, frame_err, frame_done, push, pop, empty;
  xge_word_t   push_word, head_word;
  logic [AW:0] fifo_count;
  logic [CW-1:0] occ;

  // Inflight reads count against free space so the FIFO can never overflow.
  assign occ        = CW'(fifo_count) + CW'(inflight_q);
  assign pkt_rx_ren = (state_q == StRead) && (occ < DepthL) && !(pkt_rx_val && pkt_rx_eop);

  assign sop_new   = pkt_rx_val &&  pkt_rx_sop && !in_frame_q;
  assign cont      = pkt_rx_val && !pkt_rx_sop &&  in_frame_q;
  assign orphan    = pkt_rx_val && !pkt_rx_sop && !in_frame_q;
  assign collision = pkt_rx_val &&  pkt_rx_sop &&  in_frame_q;

  always_comb begin
    state_d = state_q;
    case (state_q)
      StIdle:  if (pkt_rx_avail) state_d = StRead;
      StRead:  if (pkt_rx_val && pkt_rx_eop) state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  always_comb begin
    words     = sop_new ? 13'd1 : (wcnt_q == WcntMax) ? WcntMax : wcnt_q + 13'd1;
    mod_bytes = collision ? 4'(XGE_WORD_BYTES) : mod_to_bytes(pkt_rx_mod);
    len_raw   = {4'b0, words - 13'd1, 3'b000} + {16'b0, mod_bytes};
    frame_len = (len_raw > 20'hFFFF) ? 16'hFFFF : len_raw[15:0];
    eop_word  = collision || pkt_rx_eop;
    frame_err = collision || pkt_rx_err || (32'(frame_len) > MAX_FRAME_BYTES);
    push      = sop_new || cont || collision;
    frame_done = push && eop_word;

    // A colliding sop closes the open frame as a full-word errored eop.
    push_word.data = pkt_rx_data;
    push_word.sop  = sop_new;
    push_word.eop  = eop_word;
    push_word.mod  = collision ? 3'd0 : pkt_rx_mod;
    push_word.err  = eop_word && frame_err;

    in_frame_d = in_frame_q;
    wcnt_d     = wcnt_q;
    if (sop_new || cont) begin
      in_frame_d = !pkt_rx_eop;
      wcnt_d     = words;
    end else if (collision || orphan) begin
      in_frame_d = 1'b0;
      wcnt_d     = '0;
    end

    rx_len_d = frame_done ? frame_len : rx_len_q;
  end

  always_ff @(posedge clk_156m25 or negedge reset_156m25_n) begin
    if (!reset_156m25_n) begin
      state_q      <= StIdle;
      inflight_q   <= 1'b0;
      in_frame_q   <= 1'b0;
      wcnt_q       <= '0;
      rx_len_q     <= '0;
      rx_len_vld_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      inflight_q   <= pkt_rx_ren;
      in_frame_q   <= in_frame_d;
      wcnt_q       <= wcnt_d;
      rx_len_q     <= rx_len_d;
      rx_len_vld_q <= frame_done;
    end
  end

  assign pop = out_val && out_rdy;

  xge_rx_fifo #(
    .FIFO_DEPTH(FIFO_DEPTH)
  ) u_fifo (
    .clk_i  (clk_156m25),
    .rst_ni (reset_156m25_n),
    .push_i (push),
    .wdata_i(push_word),
    .pop_i  (pop),
    .rdata_o(head_word),
    .empty_o(empty),
    .count_o(fifo_count)
  );

  assign out_val    = !empty;
  assign out_data   = head_word.data;
  assign out_sop    = head_word.sop;
  assign out_eop    = head_word.eop;
  assign out_mod    = head_word.mod;
  assign out_err    = head_word.err;
  assign rx_len     = rx_len_q;
  assign rx_len_vld = rx_len_vld_q;

`ifdef XGE_RX_STATS_EN
  logic [31:0] ok_q, err_q;

  // Orphan drops and completed frames never coincide, so one increment per cycle suffices.
  always_ff @(posedge clk_156m25 or negedge reset_156m25_n) begin
    if (!reset_156m25_n) begin
      ok_q  <= '0;
      err_q <= '0;
    end else begin
      ok_q  <= ok_q + 32'(frame_done && !frame_err);
      err_q <= err_q + 32'((frame_done && frame_err) || orphan);
    end
  end

  assign stat_frames_ok  = ok_q;
  assign stat_frames_err = err_q;
`else
  assign stat_frames_ok  = '0;
  assign stat_frames_err = '0;
`endif

endmodule

// File: tb/tb_xge_pkt_rx_reader.sv
// Directed bench for xge_pkt_rx_reader with a responsive MAC read model.
module tb_xge_pkt_rx_reader;

`ifdef XGE_RX_STATS_EN
  localparam bit StatsOn = 1'b1;
`else
  localparam bit StatsOn = 1'b0;
`endif

  typedef struct packed {
    logic [63:0] data;
    logic        sop;
    logic        eop;
    logic [2:0]  mod;
    logic        err;
  } wd_t;

  logic        clk, rst_n;
  logic        pkt_rx_avail, pkt_rx_val, pkt_rx_sop, pkt_rx_eop, pkt_rx_err, pkt_rx_ren;
  logic [63:0] pkt_rx_data, out_data;
  logic [2:0]  pkt_rx_mod, out_mod;
  logic        out_sop, out_eop, out_err, out_val, out_rdy, rx_len_vld;
  logic [15:0] rx_len;
  logic [31:0] stat_ok, stat_err;

  int  n_tests = 0;
  int  n_fail  = 0;
  wd_t mac_q[$];
  wd_t got_q[$];
  int  words_sent, cyc, len_pulses;
  int  first_ren = -1;
  int  first_val = -1;
  int  ws0;

  xge_pkt_rx_reader #(
    .FIFO_DEPTH     (4),
    .MAX_FRAME_BYTES(1518)
  ) dut (
    .clk_156m25     (clk),
    .reset_156m25_n (rst_n),
    .pkt_rx_avail   (pkt_rx_avail),
    .pkt_rx_val     (pkt_rx_val),
    .pkt_rx_data    (pkt_rx_data),
    .pkt_rx_sop     (pkt_rx_sop),
    .pkt_rx_eop     (pkt_rx_eop),
    .pkt_rx_mod     (pkt_rx_mod),
    .pkt_rx_err     (pkt_rx_err),
    .pkt_rx_ren     (pkt_rx_ren),
    .out_data       (out_data),
    .out_sop        (out_sop),
    .out_eop        (out_eop),
    .out_err        (out_err),
    .out_mod        (out_mod),
    .out_val        (out_val),
    .out_rdy        (out_rdy),
    .rx_len         (rx_len),
    .rx_len_vld     (rx_len_vld),
    .stat_frames_ok (stat_ok),
    .stat_frames_err(stat_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  // MAC model: a read enable seen in cycle N returns the next word in cycle N+1.
  initial begin
    bit  rs;
    wd_t w;
    pkt_rx_avail = 0; pkt_rx_val = 0; pkt_rx_data = '0; pkt_rx_sop = 0;
    pkt_rx_eop = 0; pkt_rx_mod = '0; pkt_rx_err = 0; words_sent = 0; cyc = 0;
    forever begin
      @(negedge clk);
      rs = pkt_rx_ren;
      @(posedge clk);
      cyc++;
      #1;
      if (rs && mac_q.size() != 0) begin
        w = mac_q.pop_front();
        pkt_rx_val = 1; pkt_rx_data = w.data; pkt_rx_sop = w.sop;
        pkt_rx_eop = w.eop; pkt_rx_mod = w.mod; pkt_rx_err = w.err;
        words_sent++;
      end else begin
        pkt_rx_val = 0; pkt_rx_sop = 0; pkt_rx_eop = 0; pkt_rx_err = 0;
      end
      pkt_rx_avail = (mac_q.size() != 0);
    end
  end

  initial begin
    wd_t w;
    len_pulses = 0;
    forever begin
      @(negedge clk);
      if (out_val && out_rdy) begin
        w = {out_data, out_sop, out_eop, out_mod, out_err};
        got_q.push_back(w);
      end
      if (rx_len_vld) len_pulses++;
      if (pkt_rx_ren && first_ren < 0) first_ren = cyc;
      if (out_val && first_val < 0) first_val = cyc;
    end
  end

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic wd_t mk(input logic [7:0] tg, input int i, input logic s, input logic e,
                             input logic [2:0] m, input logic er);
    wd_t w;
    w.data = {tg, 24'h0, i[31:0]};
    w.sop  = s;
    w.eop  = e;
    w.mod  = m;
    w.err  = er;
    return w;
  endfunction

  task automatic load_frame(input int n, input logic [2:0] m, input logic er,
                            input logic [7:0] tg, input int sop_at);
    for (int i = 0; i < n; i++)
      mac_q.push_back(mk(tg, i, (i == 0) || (i == sop_at), i == n - 1,
                         (i == n - 1) ? m : 3'd0, (i == n - 1) ? er : 1'b0));
  endtask

  task automatic wait_words(input int n, input int budget);
    int k = 0;
    while (got_q.size() < n && k < budget) begin
      @(posedge clk);
      k++;
    end
    chk("word_count", got_q.size(), n);
    repeat (3) @(posedge clk);
    #2;
  endtask

  task automatic check_frame(input int n, input logic [2:0] m, input logic er, input logic [7:0] tg);
    for (int i = 0; i < n && i < got_q.size(); i++)
      chk($sformatf("word%0d_%0h", i, tg), got_q[i],
          mk(tg, i, i == 0, i == n - 1, (i == n - 1) ? m : 3'd0, (i == n - 1) ? er : 1'b0));
    got_q.delete();
  endtask

  initial begin
    rst_n = 0; out_rdy = 1;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_ren", pkt_rx_ren, 0);
    chk("rst_val", out_val, 0);
    chk("rst_fields", {out_data, out_sop, out_eop, out_mod, out_err}, 0);
    chk("rst_len", rx_len, 0);
    chk("rst_len_vld", rx_len_vld, 0);
    chk("rst_stats", {stat_ok, stat_err}, 0);
    rst_n = 1;
    @(posedge clk); #2;

    // 64-byte frame
    first_ren = -1; first_val = -1; len_pulses = 0;
    load_frame(8, 3'd0, 1'b0, 8'hA1, -1);
    wait_words(8, 100);
    chk("latency", first_val - first_ren, 2);
    check_frame(8, 3'd0, 1'b0, 8'hA1);
    chk("len64", rx_len, 16'd64);
    chk("len64_pulses", len_pulses, 1);
    chk("ok1", stat_ok, StatsOn ? 32'd1 : 32'd0);
    chk("err0", stat_err, 0);

    // 61-byte frame
    load_frame(8, 3'd5, 1'b0, 8'hA2, -1);
    wait_words(8, 100);
    check_frame(8, 3'd5, 1'b0, 8'hA2);
    chk("len61", rx_len, 16'd61);
    chk("ok2", stat_ok, StatsOn ? 32'd2 : 32'd0);

    // Back-pressure during a 16-word frame
    out_rdy = 0;
    ws0 = words_sent;
    load_frame(16, 3'd0, 1'b0, 8'hA3, -1);
    repeat (20) @(posedge clk);
    #2;
    chk("stall_sent", words_sent - ws0, 4);
    chk("stall_ren", pkt_rx_ren, 0);
    chk("stall_val", out_val, 1);
    chk("stall_got", got_q.size(), 0);
    out_rdy = 1;
    wait_words(16, 200);
    check_frame(16, 3'd0, 1'b0, 8'hA3);
    chk("len128", rx_len, 16'd128);
    chk("ok3", stat_ok, StatsOn ? 32'd3 : 32'd0);

    // Oversize frame
    load_frame(200, 3'd0, 1'b0, 8'hA4, -1);
    wait_words(200, 600);
    check_frame(200, 3'd0, 1'b1, 8'hA4);
    chk("len1600", rx_len, 16'd1600);
    chk("err1", stat_err, StatsOn ? 32'd1 : 32'd0);
    chk("ok3b", stat_ok, StatsOn ? 32'd3 : 32'd0);

    // MAC-reported error
    load_frame(8, 3'd0, 1'b1, 8'hA5, -1);
    wait_words(8, 100);
    check_frame(8, 3'd0, 1'b1, 8'hA5);
    chk("len64e", rx_len, 16'd64);
    chk("err2", stat_err, StatsOn ? 32'd2 : 32'd0);

    // sop collision at word 3 of 10: words 4..9 become orphans
    len_pulses = 0;
    load_frame(10, 3'd0, 1'b0, 8'hA6, 3);
    for (int k = 0; k < 100 && mac_q.size() != 0; k++) @(posedge clk);
    repeat (6) @(posedge clk);
    #2;
    chk("coll_count", got_q.size(), 4);
    for (int i = 0; i < 3 && i < got_q.size(); i++)
      chk($sformatf("coll_word%0d", i), got_q[i], mk(8'hA6, i, i == 0, 1'b0, 3'd0, 1'b0));
    if (got_q.size() > 3) chk("coll_word3", got_q[3], mk(8'hA6, 3, 1'b0, 1'b1, 3'd0, 1'b1));
    got_q.delete();
    chk("coll_len", rx_len, 16'd32);
    chk("coll_pulses", len_pulses, 1);
    chk("coll_err", stat_err, StatsOn ? 32'd9 : 32'd0);
    chk("coll_idle_ren", pkt_rx_ren, 0);

    // FSM must be back in idle and accept a fresh frame
    load_frame(8, 3'd3, 1'b0, 8'hA7, -1);
    wait_words(8, 100);
    check_frame(8, 3'd3, 1'b0, 8'hA7);
    chk("len59", rx_len, 16'd59);
    chk("ok4", stat_ok, StatsOn ? 32'd4 : 32'd0);

    // Reset at word 5 of 10
    ws0 = words_sent;
    load_frame(10, 3'd0, 1'b0, 8'hA8, -1);
    for (int k = 0; k < 100 && (words_sent - ws0) < 5; k++) begin
      @(posedge clk);
      #2;
    end
    chk("rst_mid_reach", words_sent - ws0, 5);
    rst_n = 0;
    mac_q.delete();
    #1;
    chk("rst_mid_ren", pkt_rx_ren, 0);
    chk("rst_mid_val", out_val, 0);
    chk("rst_mid_len", rx_len, 0);
    chk("rst_mid_stats", {stat_ok, stat_err}, 0);
    repeat (3) @(posedge clk);
    #1;
    rst_n = 1;
    got_q.delete();
    len_pulses = 0;
    @(posedge clk); #2;
    load_frame(8, 3'd0, 1'b0, 8'hA9, -1);
    wait_words(8, 100);
    check_frame(8, 3'd0, 1'b0, 8'hA9);
    chk("post_rst_len", rx_len, 16'd64);
    chk("post_rst_pulses", len_pulses, 1);
    chk("post_rst_ok", stat_ok, StatsOn ? 32'd1 : 32'd0);
    chk("post_rst_err", stat_err, 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
